// File: rtl/mips_bus_mem_unit.sv
// rtl/mips_bus_mem_unit.sv - load/store unit bridging the MIPS core requests to an Avalon-MM master
module mips_bus_mem_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [31:0]           writedata,
    output logic [3:0]            byteenable,
    input  logic [31:0]           readdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [CNT_WIDTH:0] TO_LIMIT = (CNT_WIDTH+1)'(TIMEOUT_CYCLES);

    state_t                state, state_next;
    logic [1:0]            lat_off;
    logic [1:0]            lat_size;
    logic                  lat_signed;
    logic [CNT_WIDTH-1:0]  wait_cnt;
    logic [CNT_WIDTH:0]    wait_cnt_inc;
    logic                  accept, misaligned, bus_done, timed_out;
    logic [3:0]            be_calc;
    logic [31:0]           wd_calc, lane, load_ext;

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign accept       = req_valid && req_ready;
    assign bus_done     = (state == BUS) && !waitrequest;
    assign wait_cnt_inc = {1'b0, wait_cnt} + 1'b1;
    assign timed_out    = (TIMEOUT_CYCLES != 0) && (state == BUS) && waitrequest
                          && (wait_cnt_inc >= TO_LIMIT);

    always_comb begin
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wd_calc    = req_wdata;
        case (req_size)
            2'd0: begin
                be_calc = 4'b0001 << req_addr[1:0];
                wd_calc = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = req_addr[0];
                be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_calc    = {2{req_wdata[15:0]}};
            end
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Selected lane is shifted down to bit 0 before masking/extension.
    always_comb begin
        lane = readdata >> {lat_off, 3'b000};
        case (lat_size)
            2'd0:    load_ext = lat_signed ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
            2'd1:    load_ext = lat_signed ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = misaligned ? RESP : BUS;
            BUS:     if (bus_done || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_off    <= 2'b00;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            wait_cnt   <= '0;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= 32'b0;
            byteenable <= 4'b0;
        end else begin
            // Response fields live for the single RESP cycle only.
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
            if (accept) begin
                lat_off    <= req_addr[1:0];
                lat_size   <= req_size;
                lat_signed <= req_signed;
                wait_cnt   <= '0;
                if (misaligned) begin
                    resp_err <= 1'b1;
                end else begin
                    address    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    read       <= !req_write;
                    write      <= req_write;
                    byteenable <= be_calc;
                    writedata  <= req_write ? wd_calc : 32'b0;
                end
            end else if (state == BUS) begin
                if (bus_done || timed_out) begin
                    if (bus_done && read) resp_rdata <= load_ext;
                    resp_err   <= timed_out;
                    wait_cnt   <= '0;
                    address    <= '0;
                    read       <= 1'b0;
                    write      <= 1'b0;
                    writedata  <= 32'b0;
                    byteenable <= 4'b0;
                end else if (!wait_cnt_inc[CNT_WIDTH]) begin
                    wait_cnt <= wait_cnt_inc[CNT_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_mem_unit.sv
// tb/tb_mips_bus_mem_unit.sv - self-checking bench for mips_bus_mem_unit
module tb_mips_bus_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid2;
    logic        req_write, req_signed, waitrequest;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, readdata;

    logic        req_ready, resp_valid, resp_err, read, write;
    logic [31:0] resp_rdata, address, writedata;
    logic [3:0]  byteenable;
    logic        req_ready2, resp_valid2, resp_err2, read2, write2;
    logic [31:0] resp_rdata2, address2, writedata2;
    logic [3:0]  byteenable2;

    always #5 clk = ~clk;

    mips_bus_mem_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(0), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address), .read(read),
        .write(write), .waitrequest(waitrequest), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata)
    );

    mips_bus_mem_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(3), .CNT_WIDTH(16)) dut_to (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid2),
        .resp_rdata(resp_rdata2), .resp_err(resp_err2), .address(address2), .read(read2),
        .write(write2), .waitrequest(waitrequest), .writedata(writedata2),
        .byteenable(byteenable2), .readdata(readdata)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stalls;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int stalls,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic [3:0] exp_be, input logic [31:0] exp_wd);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.stalls = stalls; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_be = exp_be; v.exp_wd = exp_wd;
        return v;
    endfunction

    // Reference model: expectations from the lane/extension rules using plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int unsigned o = v.addr % 4;
        int unsigned lane = v.rdata >> (8 * o);
        int unsigned b = lane % 256;
        int unsigned h = lane % 65536;
        r.exp_err = (v.size == 3) || (v.size == 1 && (o % 2) != 0) || (v.size == 2 && o != 0);
        r.exp_be  = (v.size == 0) ? 4'(1 << o) : (v.size == 1) ? ((o >= 2) ? 4'd12 : 4'd3) : 4'd15;
        r.exp_wd  = (v.size == 0) ? (v.wdata % 256) * 32'h01010101 :
                    (v.size == 1) ? (v.wdata % 65536) * 32'h00010001 : v.wdata;
        if (r.exp_err || v.wr)        r.exp_rdata = 0;
        else if (v.size == 0)         r.exp_rdata = (v.sgn && b >= 128) ? b + 32'hFFFFFF00 : b;
        else if (v.size == 1)         r.exp_rdata = (v.sgn && h >= 32768) ? h + 32'hFFFF0000 : h;
        else                          r.exp_rdata = lane;
        return r;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        req_write = v.wr; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.exp_err) begin
            chk({tag, " no bus"}, {30'b0, read, write}, 32'd0);
            chk({tag, " err resp_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, " err resp_err"}, 32'(resp_err), 32'd1);
            chk({tag, " err rdata"}, resp_rdata, 32'd0);
        end else begin
            for (int i = 0; i <= v.stalls; i++) begin
                waitrequest = (i < v.stalls);
                readdata = (i < v.stalls) ? $urandom : v.rdata;
                chk($sformatf("%s read c%0d", tag, i), 32'(read), 32'(!v.wr));
                chk($sformatf("%s write c%0d", tag, i), 32'(write), 32'(v.wr));
                chk($sformatf("%s address c%0d", tag, i), address, {v.addr[31:2], 2'b00});
                chk($sformatf("%s be c%0d", tag, i), 32'(byteenable), 32'(v.exp_be));
                if (v.wr) chk($sformatf("%s wdata c%0d", tag, i), writedata, v.exp_wd);
                chk($sformatf("%s early resp c%0d", tag, i), 32'(resp_valid), 32'd0);
                @(negedge clk);
            end
            waitrequest = 1'b0;
            chk({tag, " bus dropped"}, {30'b0, read, write}, 32'd0);
            chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, " resp_err"}, 32'(resp_err), 32'd0);
            chk({tag, " resp_rdata"}, resp_rdata, v.exp_rdata);
        end
        @(negedge clk);
        chk({tag, " resp pulse ends"}, 32'(resp_valid), 32'd0);
        chk({tag, " ready again"}, 32'(req_ready), 32'd1);
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        reset = 1'b1; req_valid = 0; req_valid2 = 0; req_write = 0; req_size = 0;
        req_signed = 0; req_addr = 0; req_wdata = 0; waitrequest = 0; readdata = 0;
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp", {29'b0, resp_valid, resp_err, 1'b0}, 32'd0);
        chk("reset rdata", resp_rdata, 32'd0);
        chk("reset rw", {30'b0, read, write}, 32'd0);
        chk("reset address", address, 32'd0);
        chk("reset writedata", writedata, 32'd0);
        chk("reset be", 32'(byteenable), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //            wr size sgn addr          wdata         rdata        st exp_rdata    err be      exp_wd
        tbl[0]  = mk(0, 2, 0, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 4'hF, 32'h0);
        tbl[1]  = mk(0, 0, 1, 32'h0000_1003, 32'h0,        32'h80FFFFFF, 0, 32'hFFFFFF80, 0, 4'h8, 32'h0);
        tbl[2]  = mk(0, 0, 0, 32'h0000_1003, 32'h0,        32'h80FFFFFF, 0, 32'h00000080, 0, 4'h8, 32'h0);
        tbl[3]  = mk(1, 1, 0, 32'h0000_2002, 32'h1234ABCD, 32'h0,        0, 32'h0,        0, 4'hC, 32'hABCDABCD);
        tbl[4]  = mk(0, 2, 0, 32'h0000_1000, 32'h0,        32'h12345678, 5, 32'h12345678, 0, 4'hF, 32'h0);
        tbl[5]  = mk(0, 2, 0, 32'h0000_1001, 32'h0,        32'h0,        0, 32'h0,        1, 4'h0, 32'h0);
        tbl[6]  = mk(0, 1, 1, 32'h0000_1002, 32'h0,        32'h80017FFF, 1, 32'hFFFF8001, 0, 4'hC, 32'h0);
        tbl[7]  = mk(0, 1, 0, 32'h0000_1000, 32'h0,        32'h8001F00D, 0, 32'h0000F00D, 0, 4'h3, 32'h0);
        tbl[8]  = mk(1, 0, 0, 32'h0000_3001, 32'h000000A5, 32'h0,        2, 32'h0,        0, 4'h2, 32'hA5A5A5A5);
        tbl[9]  = mk(1, 2, 0, 32'h0000_3004, 32'hCAFEF00D, 32'h0,        0, 32'h0,        0, 4'hF, 32'hCAFEF00D);
        tbl[10] = mk(0, 3, 0, 32'h0000_1000, 32'h0,        32'h0,        0, 32'h0,        1, 4'h0, 32'h0);
        tbl[11] = mk(1, 1, 0, 32'h0000_2001, 32'h5555AAAA, 32'h0,        0, 32'h0,        1, 4'h0, 32'h0);
        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++) begin
            rv.wr = 1'($urandom); rv.size = 2'($urandom); rv.sgn = 1'($urandom);
            rv.addr = $urandom; rv.wdata = $urandom; rv.rdata = $urandom;
            rv.stalls = $urandom_range(0, 3);
            rv = model(rv);
            apply(rv, $sformatf("rnd%0d", i));
        end

        // Timeout: three stall cycles then abort with error.
        req_write = 0; req_size = 2; req_signed = 0; req_addr = 32'h1000; waitrequest = 1;
        req_valid2 = 1;
        @(negedge clk);
        req_valid2 = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("to read c%0d", i), {30'b0, read2, write2}, 32'd2);
            chk($sformatf("to address c%0d", i), address2, 32'h1000);
            chk($sformatf("to be c%0d", i), 32'(byteenable2), 32'hF);
            chk($sformatf("to no resp c%0d", i), 32'(resp_valid2), 32'd0);
            @(negedge clk);
        end
        chk("to read dropped", 32'(read2), 32'd0);
        chk("to resp_valid", 32'(resp_valid2), 32'd1);
        chk("to resp_err", 32'(resp_err2), 32'd1);
        chk("to resp_rdata", resp_rdata2, 32'd0);
        @(negedge clk);
        chk("to ready again", 32'(req_ready2), 32'd1);

        // Reset while a stalled read is in flight.
        req_valid2 = 1;
        @(negedge clk);
        req_valid2 = 0;
        chk("rst read before", 32'(read2), 32'd1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst read dropped", 32'(read2), 32'd0);
        chk("rst wdata zero", writedata2, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst no resp c%0d", i), 32'(resp_valid2), 32'd0);
            chk($sformatf("rst idle c%0d", i), 32'(req_ready2), 32'd1);
            @(negedge clk);
        end
        waitrequest = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
